// File: rtl/datapath_pkg.sv
// Shared definitions for param_datapath: op codes, FSM states
// and the saturating-add helper.
package datapath_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_MAC = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Widest datapath the helper supports.
    localparam int DP_MAX_W = 64;

    // w-bit unsigned add that clamps to all-ones on carry out.
    // Operands must already fit in w bits.
    function automatic logic [DP_MAX_W-1:0] sat_add(
        input logic [DP_MAX_W-1:0] x,
        input logic [DP_MAX_W-1:0] y,
        input int unsigned         w
    );
        logic [DP_MAX_W:0]   s;
        logic [DP_MAX_W-1:0] ones;
        ones = {DP_MAX_W{1'b1}} >> (DP_MAX_W - w);
        s    = {1'b0, x} + {1'b0, y};
        // s < 2^(w+1), so anything above bit w-1 is the carry
        if ((s >> w) != '0)
            sat_add = ones;
        else
            sat_add = s[DP_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/param_datapath_seq_mult.sv
// seq_mult: unsigned shift-add multiplier, one step per clock, LSB first.
// Ports: clk, rst (sync, high), load (latch operands, clear product),
//        mcand/mplier [HALF-1:0], busy, last (final step), product.
module seq_mult #(
    parameter int HALF = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [HALF-1:0]   mcand,
    input  logic [HALF-1:0]   mplier,
    output logic              busy,
    output logic              last,
    output logic [2*HALF-1:0] product
);

    localparam int CW = $clog2(HALF + 1);

    logic [2*HALF-1:0] mcand_q;
    logic [2*HALF-1:0] prod_q;
    logic [HALF-1:0]   mplier_q;
    logic [CW-1:0]     cnt;

    assign busy = (cnt != '0);
    assign last = (cnt == CW'(1));

    // product already includes the step taken in the current cycle,
    // so on the last step it is the final value the top registers.
    assign product = (busy && mplier_q[0]) ? prod_q + mcand_q : prod_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt      <= '0;
        end else if (load) begin
            mcand_q  <= {{HALF{1'b0}}, mcand};
            mplier_q <= mplier;
            prod_q   <= '0;
            cnt      <= CW'(HALF);
        end else if (busy) begin
            prod_q   <= product;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt      <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/param_datapath.sv
// param_datapath: multi-cycle add/sub/mul/mac with start/ready/done handshake.
// Ports: clk, rst (sync, high), start, sel[1:0], a/b [WIDTH-1:0],
//        c/d [HALF-1:0] -> ready, done (1-cycle pulse), result, ovf.
// Option: define DATAPATH_SATURATE_EN to clamp add/mac/sub instead of wrapping.
module param_datapath
    import datapath_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           sel,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH/2-1:0]   c,
    input  logic [WIDTH/2-1:0]   d,
    output logic                 ready,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic                 ovf
);

    localparam int HALF = WIDTH / 2;

    state_t           state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;

    logic             load;
    logic             mult_busy;
    logic             mult_last;
    logic [WIDTH-1:0] product;
    logic             exec_fin;

    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH:0]   mac_ext;
    logic [WIDTH-1:0] add_val;
    logic [WIDTH-1:0] sub_val;
    logic [WIDTH-1:0] mac_val;
    logic [WIDTH-1:0] res_val;
    logic             ovf_val;

    assign ready = (state == S_IDLE);
    assign load  = ready && start;

    seq_mult #(
        .HALF (HALF)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .mcand   (c),
        .mplier  (d),
        .busy    (mult_busy),
        .last    (mult_last),
        .product (product)
    );

    // add/sub finish after one EXEC cycle, mul/mac on the multiplier's last step
    assign exec_fin = op_q[1] ? (mult_busy && mult_last) : 1'b1;

    assign add_ext = {1'b0, a_q} + {1'b0, b_q};
    assign sub_ext = {1'b0, a_q} - {1'b0, b_q};
    assign mac_ext = {1'b0, acc_q} + {1'b0, product};

`ifdef DATAPATH_SATURATE_EN
    logic [DP_MAX_W-1:0] add_sat;
    logic [DP_MAX_W-1:0] mac_sat;

    assign add_sat = sat_add(DP_MAX_W'(a_q), DP_MAX_W'(b_q), WIDTH);
    assign mac_sat = sat_add(DP_MAX_W'(acc_q), DP_MAX_W'(product), WIDTH);
    assign add_val = add_sat[WIDTH-1:0];
    assign mac_val = mac_sat[WIDTH-1:0];
    assign sub_val = sub_ext[WIDTH] ? '0 : sub_ext[WIDTH-1:0];
`else
    assign add_val = add_ext[WIDTH-1:0];
    assign mac_val = mac_ext[WIDTH-1:0];
    assign sub_val = sub_ext[WIDTH-1:0];
`endif

    always_comb begin
        res_val = '0;
        ovf_val = 1'b0;
        unique case (op_q)
            OP_ADD: begin
                res_val = add_val;
                ovf_val = add_ext[WIDTH];
            end
            OP_SUB: begin
                res_val = sub_val;
                ovf_val = sub_ext[WIDTH];
            end
            OP_MUL: begin
                res_val = product;
                ovf_val = 1'b0;
            end
            OP_MAC: begin
                res_val = mac_val;
                ovf_val = mac_ext[WIDTH];
            end
            default: begin
                res_val = '0;
                ovf_val = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            done   <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q  <= sel;
                        a_q   <= a;
                        b_q   <= b;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_fin) begin
                        result <= res_val;
                        ovf    <= ovf_val;
                        done   <= 1'b1;
                        if (op_q == OP_MAC)
                            acc_q <= mac_val;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_datapath.sv
// Self-checking bench for param_datapath (WIDTH=8): directed cases,
// handshake/reset corner cases and randomized ops against a reference model.
module tb_param_datapath;

    localparam int W    = 8;
    localparam int H    = W / 2;
    localparam int MODW = 1 << W;
`ifdef DATAPATH_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   sel = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [H-1:0] c = '0;
    logic [H-1:0] d = '0;
    logic         ready;
    logic         done;
    logic [W-1:0] result;
    logic         ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int acc_m   = 0;

    param_datapath #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sel    (sel),
        .a      (a),
        .b      (b),
        .c      (c),
        .d      (d),
        .ready  (ready),
        .done   (done),
        .result (result),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the op definitions.
    task automatic model(input int s, input int av, input int bv,
                         input int cv, input int dv,
                         output int res, output int ov);
        int t;
        case (s)
            0: begin
                t   = av + bv;
                ov  = (t >= MODW) ? 1 : 0;
                res = ov ? (SAT ? MODW - 1 : t - MODW) : t;
            end
            1: begin
                ov  = (av < bv) ? 1 : 0;
                res = ov ? (SAT ? 0 : av - bv + MODW) : av - bv;
            end
            2: begin
                res = cv * dv;
                ov  = 0;
            end
            default: begin
                t     = acc_m + cv * dv;
                ov    = (t >= MODW) ? 1 : 0;
                res   = ov ? (SAT ? MODW - 1 : t - MODW) : t;
                acc_m = res;
            end
        endcase
    endtask

    // Waits for done after the accept edge; returns edges counted.
    task automatic wait_done(output int cnt);
        cnt = 1;
        while (!done && cnt < 20) begin
            check("busy_ready", ready, 0);
            @(posedge clk); #1;
            cnt++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic run_op(input int s, input int av, input int bv,
                          input int cv, input int dv);
        int er, eo, cnt;
        model(s, av, bv, cv, dv, er, eo);
        @(negedge clk);
        sel   = 2'(s);
        a     = W'(av);
        b     = W'(bv);
        c     = H'(cv);
        d     = H'(dv);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        c = H'($urandom);
        d = H'($urandom);
        sel = 2'($urandom);
        wait_done(cnt);
        check("latency", cnt, (s >= 2) ? H + 1 : 2);
        check("result", result, er);
        check("ovf", ovf, eo);
        check("ready_at_done", ready, 0);
        @(posedge clk); #1;
        check("done_pulse", done, 0);
        check("ready_back", ready, 1);
        check("result_hold", result, er);
    endtask

    initial begin
        int er, eo, cnt;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_ovf", ovf, 0);

        // Directed cases
        run_op(0, 'hA5, 'h61, 0, 0);
        run_op(1, 'hA5, 'h61, 0, 0);
        run_op(1, 'h61, 'hA5, 0, 0);
        run_op(2, 0, 0, 'hA, 'h6);
        run_op(3, 0, 0, 'hF, 'hF);
        run_op(3, 0, 0, 'hF, 'hF);
        run_op(0, 'hFF, 'h01, 0, 0);
        run_op(1, 'h33, 'h33, 0, 0);
        run_op(2, 0, 0, 'hF, 'hF);

        // start held high through a mul, operands changed after accept
        @(negedge clk);
        sel = 2'd2; c = 4'h3; d = 4'h5; start = 1'b1;
        @(posedge clk); #1;
        c = 4'h7; d = 4'h9;
        wait_done(cnt);
        model(2, 0, 0, 3, 5, er, eo);
        check("held_lat1", cnt, H + 1);
        check("held_res1", result, er);
        @(posedge clk); #1;
        check("held_ready_n6", ready, 1);
        check("held_done_n6", done, 0);
        @(posedge clk); #1;
        check("held_accept", ready, 0);
        start = 1'b0;
        wait_done(cnt);
        model(2, 0, 0, 7, 9, er, eo);
        check("held_lat2", cnt, H + 1);
        check("held_res2", result, er);
        @(posedge clk); #1;
        check("held_idle1", ready, 1);
        @(posedge clk); #1;
        check("held_idle2", ready, 1);
        check("held_nodone", done, 0);

        // Reset in the middle of a mul
        @(negedge clk);
        sel = 2'd2; c = 4'hA; d = 4'hB; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        acc_m = 0;
        check("mid_rst_ready", ready, 1);
        check("mid_rst_done", done, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_ovf", ovf, 0);
        repeat (6) begin
            @(posedge clk); #1;
            check("mid_rst_nodone", done, 0);
        end
        run_op(0, 1, 1, 0, 0);
        run_op(3, 0, 0, 1, 1);

        // Randomized ops
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, MODW - 1)),
                   int'($urandom_range(0, MODW - 1)),
                   int'($urandom_range(0, (1 << H) - 1)),
                   int'($urandom_range(0, (1 << H) - 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
